alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
ID→EX issue stage that produces the ALU's operand/operation interface.
- Decodes a 32-bit MIPS R/I-type instruction plus register-file read data into datoA, datoB, operation, shamt and destination register.
- Registers the decoded result behind a valid/ready handshake with a 2-entry skid buffer, so the EX stage can stall without losing or duplicating instructions.

Parameters:
NB_DATA, 32, operand width; must be ≥ 32 for LUI results to be meaningful.
NB_OP, 6, ALU operation code width.
NB_REG, 5, register index width.

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset, asynchronous, active-low
i_valid  in  1  upstream instruction valid
o_ready  out  1  stage can accept; registered
i_instruction  in  32  instruction word
i_rs_data  in  NB_DATA  register-file read of rs
i_rt_data  in  NB_DATA  register-file read of rt
i_flush  in  1  synchronous flush of all held entries
o_valid  out  1  output entry valid
i_ready  in  1  EX stage accepts
o_datoA  out  NB_DATA  ALU operand A
o_datoB  out  NB_DATA  ALU operand B
o_operation  out  NB_OP  ALU operation code
o_shamt  out  5  shift amount
o_wr_reg  out  NB_REG  destination register
o_wr_en  out  1  register write enable
o_illegal  out  1  entry decoded as unsupported

Behaviour:
Reset:
- All outputs 0, except o_operation = 6'b111111 (IDLE) and o_ready = 1.
- State EMPTY.

Decode (combinational, captured on accept):
- Fields: opcode = instr[31:26], rs = [25:21], rt = [20:16], rd = [15:11], sh = [10:6], funct = [5:0], imm = [15:0].
- R-type (opcode 0):
  - Legal funct: 20,21,22,23,24,25,26,27,2A,2B,00,02,03,04,06,07 (hex).
  - operation = funct; A = rs_data; B = rt_data; shamt = sh; wr_reg = rd.
- I-type:
  - Legal opcodes: 08,09,0A,0B,0C,0D,0E,0F (hex).
  - operation = opcode; A = rs_data; shamt = 0; wr_reg = rt.
  - B = sign-extended imm for 08/09/0A/0B; zero-extended imm for 0C/0D/0E/0F. The ALU performs the <<16 for LUI.
- wr_en = legal && (wr_reg != 0).
- Any other encoding: operation = IDLE, A = B = 0, shamt = 0, wr_en = 0, illegal = 1. The entry still flows through the stage.

Handshake:
- Accept when i_valid && o_ready.
- Output transfer when o_valid && i_ready.
- Latency: 1 cycle from accept to o_valid when the stage is EMPTY.

State machine (main register M drives outputs; skid register S):
- EMPTY:
  - accept → ONE, M = decoded.
- ONE:
  - accept && transfer → ONE, M = new.
  - accept && !transfer → FULL, S = new.
  - transfer only → EMPTY.
- FULL:
  - transfer → ONE, M = S.
  - Inputs are not accepted.
- o_ready = (state != FULL), registered from the next state.
- o_valid = (state != EMPTY).
- Order is strictly preserved.

Flush:
- i_flush has priority over every other event. Next state is EMPTY, o_valid = 0, o_ready = 1.
- An input presented in the flush cycle is discarded.
- Output data registers return to reset values.

Other rules:
- Simultaneous accept and transfer in ONE keeps occupancy unchanged.
- While o_valid && !i_ready, outputs hold stable.
- Reset asserted mid-operation clears to EMPTY immediately (asynchronous).

Optional Feature:
Macro ALU_ISSUE_STATS_EN.
- When defined, adds two outputs:
  - o_issue_count (32): transfers with !illegal.
  - o_illegal_count (16): transfers with illegal.
- Both counters reset to 0, wrap modulo 2^N and are cleared by flush.
- When undefined, the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package alu_pkg holds:
  - all ALU operation codes (R-type funct and I-type opcode values);
  - IDLE_OP;
  - R_TYPE opcode constant;
  - a decoded-entry struct/field widths;
  - legality function.
- One natural sub-module: alu_op_decoder, purely combinational decode, instantiated once and feeding the skid buffer.

Test Plan:
1. add $3,$1,$2 (0x00221820), rs=5, rt=7, i_ready=1 → next cycle o_valid=1, op=6'h20, A=5, B=7, wr_reg=3, wr_en=1.
2. Immediate extension:
   - addi $2,$1,-1 (0x2022FFFF) → op=6'h08, B=0xFFFFFFFF, wr_reg=2.
   - andi (0x3022FFFF) → B=0x0000FFFF.
   - lui $1 (0x3C01ABCD) → op=6'h0F, B=0x0000ABCD, shamt=0.
3. Backpressure: i_ready=0, offer 3 back-to-back instructions → two accepted; o_ready=0 the cycle after the second; third held upstream. Then i_ready=1 → outputs in order, one per cycle, no loss or duplication.
4. Flush in FULL with i_valid=1 → next cycle o_valid=0, o_ready=1. Flushed and presented entries never appear; stats counters are 0.
5. Illegal and NOP:
   - lw (0x8C220000) → o_illegal=1, op=6'h3F, wr_en=0.
   - 0x00000000 (sll $0) → legal, op=6'h00, wr_en=0.
6. Reset asserted asynchronously in FULL mid-cycle → outputs at reset values immediately. After release, the first accept shows 1-cycle latency.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: operation codes, decoded
// control payload, FSM state encoding and decode legality helpers.
package alu_pkg;

   localparam int unsigned NB_INSTR   = 32;
   localparam int unsigned NB_IMM     = 16;
   localparam int unsigned NB_OP_W    = 6;
   localparam int unsigned NB_SHAMT_W = 5;
   localparam int unsigned NB_REG_W   = 5;

   localparam logic [NB_OP_W-1:0] R_TYPE  = 6'h00;
   localparam logic [NB_OP_W-1:0] IDLE_OP = 6'h3F;

   // R-type funct values
   localparam logic [NB_OP_W-1:0] OP_SLL  = 6'h00;
   localparam logic [NB_OP_W-1:0] OP_SRL  = 6'h02;
   localparam logic [NB_OP_W-1:0] OP_SRA  = 6'h03;
   localparam logic [NB_OP_W-1:0] OP_SLLV = 6'h04;
   localparam logic [NB_OP_W-1:0] OP_SRLV = 6'h06;
   localparam logic [NB_OP_W-1:0] OP_SRAV = 6'h07;
   localparam logic [NB_OP_W-1:0] OP_ADD  = 6'h20;
   localparam logic [NB_OP_W-1:0] OP_ADDU = 6'h21;
   localparam logic [NB_OP_W-1:0] OP_SUB  = 6'h22;
   localparam logic [NB_OP_W-1:0] OP_SUBU = 6'h23;
   localparam logic [NB_OP_W-1:0] OP_AND  = 6'h24;
   localparam logic [NB_OP_W-1:0] OP_OR   = 6'h25;
   localparam logic [NB_OP_W-1:0] OP_XOR  = 6'h26;
   localparam logic [NB_OP_W-1:0] OP_NOR  = 6'h27;
   localparam logic [NB_OP_W-1:0] OP_SLT  = 6'h2A;
   localparam logic [NB_OP_W-1:0] OP_SLTU = 6'h2B;

   // I-type opcode values
   localparam logic [NB_OP_W-1:0] OP_ADDI  = 6'h08;
   localparam logic [NB_OP_W-1:0] OP_ADDIU = 6'h09;
   localparam logic [NB_OP_W-1:0] OP_SLTI  = 6'h0A;
   localparam logic [NB_OP_W-1:0] OP_SLTIU = 6'h0B;
   localparam logic [NB_OP_W-1:0] OP_ANDI  = 6'h0C;
   localparam logic [NB_OP_W-1:0] OP_ORI   = 6'h0D;
   localparam logic [NB_OP_W-1:0] OP_XORI  = 6'h0E;
   localparam logic [NB_OP_W-1:0] OP_LUI   = 6'h0F;

   // Decoded control fields carried alongside the two operands
   typedef struct packed {
      logic [NB_OP_W-1:0]    operation;
      logic [NB_SHAMT_W-1:0] shamt;
      logic [NB_REG_W-1:0]   wr_reg;
      logic                  wr_en;
      logic                  illegal;
   } alu_ctl_t;

   localparam alu_ctl_t CTL_RESET = '{operation: IDLE_OP, shamt: '0,
                                      wr_reg: '0, wr_en: 1'b0, illegal: 1'b0};

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   function automatic logic is_legal_funct(input logic [NB_OP_W-1:0] funct);
      case (funct)
         OP_SLL, OP_SRL, OP_SRA, OP_SLLV, OP_SRLV, OP_SRAV,
         OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_AND, OP_OR,
         OP_XOR, OP_NOR, OP_SLT, OP_SLTU: is_legal_funct = 1'b1;
         default:                         is_legal_funct = 1'b0;
      endcase
   endfunction

   function automatic logic is_legal_iop(input logic [NB_OP_W-1:0] opcode);
      case (opcode)
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
         OP_ANDI, OP_ORI, OP_XORI, OP_LUI: is_legal_iop = 1'b1;
         default:                          is_legal_iop = 1'b0;
      endcase
   endfunction

   // Arithmetic/compare immediates are sign-extended, logical/LUI zero-extended
   function automatic logic is_sign_ext_iop(input logic [NB_OP_W-1:0] opcode);
      case (opcode)
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: is_sign_ext_iop = 1'b1;
         default:                             is_sign_ext_iop = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Purely combinational MIPS R/I-type decode into ALU operands and controls.
// Ports: i_instruction (32b word), i_rs_data / i_rt_data (register reads),
//        o_dato_a_c / o_dato_b_c (operands), o_ctl_c (decoded control payload).
module alu_op_decoder
   import alu_pkg::*;
#(
   parameter int unsigned NB_DATA = 32
) (
   input  logic [NB_INSTR-1:0] i_instruction,
   input  logic [NB_DATA-1:0]  i_rs_data,
   input  logic [NB_DATA-1:0]  i_rt_data,
   output logic [NB_DATA-1:0]  o_dato_a_c,
   output logic [NB_DATA-1:0]  o_dato_b_c,
   output alu_ctl_t            o_ctl_c
);

   logic [NB_OP_W-1:0]    opcode;
   logic [NB_REG_W-1:0]   rt_idx;
   logic [NB_REG_W-1:0]   rd_idx;
   logic [NB_SHAMT_W-1:0] sh;
   logic [NB_OP_W-1:0]    funct;
   logic [NB_IMM-1:0]     imm;
   logic                  unused_rs_idx;

   assign opcode = i_instruction[31:26];
   assign rt_idx = i_instruction[20:16];
   assign rd_idx = i_instruction[15:11];
   assign sh     = i_instruction[10:6];
   assign funct  = i_instruction[5:0];
   assign imm    = i_instruction[15:0];

   // rs index selects the register-file read upstream; only its data is used here
   assign unused_rs_idx = ^i_instruction[25:21];

   // Unsupported encodings fall through the defaults as an illegal IDLE entry
   always_comb begin
      o_dato_a_c      = '0;
      o_dato_b_c      = '0;
      o_ctl_c         = CTL_RESET;
      o_ctl_c.illegal = 1'b1;
      if (opcode == R_TYPE && is_legal_funct(funct)) begin
         o_dato_a_c        = i_rs_data;
         o_dato_b_c        = i_rt_data;
         o_ctl_c.operation = funct;
         o_ctl_c.shamt     = sh;
         o_ctl_c.wr_reg    = rd_idx;
         o_ctl_c.illegal   = 1'b0;
      end else if (is_legal_iop(opcode)) begin
         o_dato_a_c        = i_rs_data;
         o_dato_b_c        = is_sign_ext_iop(opcode)
                           ? {{(NB_DATA-NB_IMM){imm[NB_IMM-1]}}, imm}
                           : {{(NB_DATA-NB_IMM){1'b0}}, imm};
         o_ctl_c.operation = opcode;
         o_ctl_c.wr_reg    = rt_idx;
         o_ctl_c.illegal   = 1'b0;
      end
      o_ctl_c.wr_en = !o_ctl_c.illegal && (o_ctl_c.wr_reg != '0);
   end

endmodule

// File: rtl/alu_issue_stage.sv
// ID->EX issue stage: decodes an instruction plus register reads and holds the
// result in a 2-entry skid buffer behind a valid/ready handshake.
// Ports: i_valid/o_ready (upstream), o_valid/i_ready (EX), i_flush, decoded
//        outputs o_datoA/o_datoB/o_operation/o_shamt/o_wr_reg/o_wr_en/o_illegal.
// Optional: define ALU_ISSUE_STATS_EN to add o_issue_count / o_illegal_count.
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int unsigned NB_DATA = 32,
   parameter int unsigned NB_OP   = 6,
   parameter int unsigned NB_REG  = 5
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic [NB_INSTR-1:0]   i_instruction,
   input  logic [NB_DATA-1:0]    i_rs_data,
   input  logic [NB_DATA-1:0]    i_rt_data,
   input  logic                  i_flush,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [NB_DATA-1:0]    o_datoA,
   output logic [NB_DATA-1:0]    o_datoB,
   output logic [NB_OP-1:0]      o_operation,
   output logic [NB_SHAMT_W-1:0] o_shamt,
   output logic [NB_REG-1:0]     o_wr_reg,
   output logic                  o_wr_en,
`ifdef ALU_ISSUE_STATS_EN
   output logic                  o_illegal,
   output logic [31:0]           o_issue_count,
   output logic [15:0]           o_illegal_count
`else
   output logic                  o_illegal
`endif
);

   logic [NB_DATA-1:0] dec_a_c;
   logic [NB_DATA-1:0] dec_b_c;
   alu_ctl_t           dec_ctl_c;

   alu_op_decoder #(.NB_DATA(NB_DATA)) u_decoder (
      .i_instruction (i_instruction),
      .i_rs_data     (i_rs_data),
      .i_rt_data     (i_rt_data),
      .o_dato_a_c    (dec_a_c),
      .o_dato_b_c    (dec_b_c),
      .o_ctl_c       (dec_ctl_c)
   );

   state_t             state_q,  state_d;
   logic [NB_DATA-1:0] m_a_q,    m_a_d;
   logic [NB_DATA-1:0] m_b_q,    m_b_d;
   alu_ctl_t           m_ctl_q,  m_ctl_d;
   logic [NB_DATA-1:0] s_a_q,    s_a_d;
   logic [NB_DATA-1:0] s_b_q,    s_b_d;
   alu_ctl_t           s_ctl_q,  s_ctl_d;
   logic               ready_q,  ready_d;
   logic               valid_q,  valid_d;
`ifdef ALU_ISSUE_STATS_EN
   logic [31:0]        issue_cnt_q,   issue_cnt_d;
   logic [15:0]        illegal_cnt_q, illegal_cnt_d;
`endif

   logic accept_c;
   logic xfer_c;

   assign accept_c = i_valid && ready_q;
   assign xfer_c   = valid_q && i_ready;

   // State and data registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_EMPTY;
         m_a_q   <= '0;
         m_b_q   <= '0;
         m_ctl_q <= CTL_RESET;
         s_a_q   <= '0;
         s_b_q   <= '0;
         s_ctl_q <= CTL_RESET;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
`ifdef ALU_ISSUE_STATS_EN
         issue_cnt_q   <= '0;
         illegal_cnt_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         m_a_q   <= m_a_d;
         m_b_q   <= m_b_d;
         m_ctl_q <= m_ctl_d;
         s_a_q   <= s_a_d;
         s_b_q   <= s_b_d;
         s_ctl_q <= s_ctl_d;
         ready_q <= ready_d;
         valid_q <= valid_d;
`ifdef ALU_ISSUE_STATS_EN
         issue_cnt_q   <= issue_cnt_d;
         illegal_cnt_q <= illegal_cnt_d;
`endif
      end
   end

   // Next-state: flush wins over any handshake event
   always_comb begin
      state_d = state_q;
      if (i_flush) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: if (accept_c) state_d = ST_ONE;
            ST_ONE: begin
               if (accept_c && !xfer_c)      state_d = ST_FULL;
               else if (!accept_c && xfer_c) state_d = ST_EMPTY;
            end
            ST_FULL:  if (xfer_c) state_d = ST_ONE;
            default:  state_d = ST_EMPTY;
         endcase
      end
   end

   // Datapath/output updates; M always holds the oldest entry
   always_comb begin
      m_a_d   = m_a_q;
      m_b_d   = m_b_q;
      m_ctl_d = m_ctl_q;
      s_a_d   = s_a_q;
      s_b_d   = s_b_q;
      s_ctl_d = s_ctl_q;
      if (i_flush) begin
         m_a_d   = '0;
         m_b_d   = '0;
         m_ctl_d = CTL_RESET;
         s_a_d   = '0;
         s_b_d   = '0;
         s_ctl_d = CTL_RESET;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (accept_c) begin
                  m_a_d   = dec_a_c;
                  m_b_d   = dec_b_c;
                  m_ctl_d = dec_ctl_c;
               end
            end
            ST_ONE: begin
               if (accept_c && xfer_c) begin
                  m_a_d   = dec_a_c;
                  m_b_d   = dec_b_c;
                  m_ctl_d = dec_ctl_c;
               end else if (accept_c) begin
                  s_a_d   = dec_a_c;
                  s_b_d   = dec_b_c;
                  s_ctl_d = dec_ctl_c;
               end
            end
            ST_FULL: begin
               if (xfer_c) begin
                  m_a_d   = s_a_q;
                  m_b_d   = s_b_q;
                  m_ctl_d = s_ctl_q;
               end
            end
            default: ;
         endcase
      end
      ready_d = (state_d != ST_FULL);
      valid_d = (state_d != ST_EMPTY);
   end

`ifdef ALU_ISSUE_STATS_EN
   // Transfer counters split by legality; wrap naturally
   always_comb begin
      issue_cnt_d   = issue_cnt_q;
      illegal_cnt_d = illegal_cnt_q;
      if (i_flush) begin
         issue_cnt_d   = '0;
         illegal_cnt_d = '0;
      end else if (xfer_c) begin
         if (m_ctl_q.illegal) illegal_cnt_d = illegal_cnt_q + 16'd1;
         else                 issue_cnt_d   = issue_cnt_q + 32'd1;
      end
   end

   assign o_issue_count   = issue_cnt_q;
   assign o_illegal_count = illegal_cnt_q;
`endif

   assign o_ready     = ready_q;
   assign o_valid     = valid_q;
   assign o_datoA     = m_a_q;
   assign o_datoB     = m_b_q;
   assign o_operation = NB_OP'(m_ctl_q.operation);
   assign o_shamt     = m_ctl_q.shamt;
   assign o_wr_reg    = NB_REG'(m_ctl_q.wr_reg);
   assign o_wr_en     = m_ctl_q.wr_en;
   assign o_illegal   = m_ctl_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: accepted inputs are modelled and queued,
// transfers are popped and compared; directed cases plus randomized traffic.
module tb_alu_issue_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_valid;
   logic        o_ready;
   logic [31:0] i_instruction;
   logic [31:0] i_rs_data;
   logic [31:0] i_rt_data;
   logic        i_flush;
   logic        o_valid;
   logic        i_ready;
   logic [31:0] o_datoA;
   logic [31:0] o_datoB;
   logic [5:0]  o_operation;
   logic [4:0]  o_shamt;
   logic [4:0]  o_wr_reg;
   logic        o_wr_en;
   logic        o_illegal;
`ifdef ALU_ISSUE_STATS_EN
   logic [31:0] o_issue_count;
   logic [15:0] o_illegal_count;
`endif

   alu_issue_stage #(.NB_DATA(32), .NB_OP(6), .NB_REG(5)) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_valid       (i_valid),
      .o_ready       (o_ready),
      .i_instruction (i_instruction),
      .i_rs_data     (i_rs_data),
      .i_rt_data     (i_rt_data),
      .i_flush       (i_flush),
      .o_valid       (o_valid),
      .i_ready       (i_ready),
      .o_datoA       (o_datoA),
      .o_datoB       (o_datoB),
      .o_operation   (o_operation),
      .o_shamt       (o_shamt),
      .o_wr_reg      (o_wr_reg),
      .o_wr_en       (o_wr_en),
`ifdef ALU_ISSUE_STATS_EN
      .o_illegal       (o_illegal),
      .o_issue_count   (o_issue_count),
      .o_illegal_count (o_illegal_count)
`else
      .o_illegal     (o_illegal)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [5:0]  op;
      logic [4:0]  sh;
      logic [4:0]  wr;
      logic        en;
      logic        ill;
   } exp_t;

   exp_t        sb_q[$];
   int          errors = 0;
   int          checks = 0;
   int unsigned exp_issue = 0;
   int unsigned exp_illc  = 0;

   // Reference decode written straight from the instruction-set tables
   function automatic exp_t model(input logic [31:0] ins, input logic [31:0] rs,
                                  input logic [31:0] rt);
      exp_t        e;
      logic [5:0]  opc;
      logic [5:0]  fn;
      logic [15:0] imm;
      opc = ins[31:26];
      fn  = ins[5:0];
      imm = ins[15:0];
      e   = '{a: 0, b: 0, op: 6'h3F, sh: 0, wr: 0, en: 0, ill: 1};
      if (opc == 6'h00 && (fn inside {[6'h20:6'h27], 6'h2A, 6'h2B, 6'h00,
                                      6'h02, 6'h03, 6'h04, 6'h06, 6'h07})) begin
         e = '{a: rs, b: rt, op: fn, sh: ins[10:6], wr: ins[15:11], en: 0, ill: 0};
      end else if (opc inside {[6'h08:6'h0F]}) begin
         e = '{a: rs, b: 0, op: opc, sh: 0, wr: ins[20:16], en: 0, ill: 0};
         if (opc < 6'h0C) e.b = 32'($signed(imm));
         else             e.b = {16'h0, imm};
      end
      e.en = !e.ill && (e.wr != 0);
      return e;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [5:0]  rfn [16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                                6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04,
                                6'h06, 6'h07};
      logic [31:0] r;
      int unsigned sel;
      r   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel <= 3)      r = {6'h00, r[25:6], rfn[$urandom_range(0, 15)]};
      else if (sel <= 6) r = {6'(8 + $urandom_range(0, 7)), r[25:0]};
      else if (sel == 7) r = 32'h0;
      else if (sel == 9) r = {6'h23, r[25:0]};
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Input monitor: model every accepted instruction
   always @(negedge clk) begin
      if (rst_n && !i_flush && i_valid && o_ready)
         sb_q.push_back(model(i_instruction, i_rs_data, i_rt_data));
   end

   // Flush discards everything the stage holds, stats included
   always @(negedge clk) begin
      if (rst_n && i_flush) begin
         sb_q.delete();
         exp_issue = 0;
         exp_illc  = 0;
      end
   end

   // Output monitor: every transfer must match the oldest expected entry
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && !i_flush && o_valid && i_ready) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow: got op=%0h with no expected entry", o_operation);
         end else begin
            e = sb_q.pop_front();
            checks++;
            if ({o_datoA, o_datoB, o_operation, o_shamt, o_wr_reg, o_wr_en, o_illegal} !==
                {e.a, e.b, e.op, e.sh, e.wr, e.en, e.ill}) begin
               errors++;
               $display("FAIL sb_entry: got A=%h B=%h op=%h sh=%0d wr=%0d en=%b ill=%b expected A=%h B=%h op=%h sh=%0d wr=%0d en=%b ill=%b",
                        o_datoA, o_datoB, o_operation, o_shamt, o_wr_reg, o_wr_en, o_illegal,
                        e.a, e.b, e.op, e.sh, e.wr, e.en, e.ill);
            end
            if (e.ill) exp_illc++;
            else       exp_issue++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one instruction and wait (bounded) until it is accepted
   task automatic send(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
      logic acc;
      i_valid       = 1'b1;
      i_instruction = ins;
      i_rs_data     = rs;
      i_rt_data     = rt;
      for (int n = 0; n < 50; n++) begin
         acc = o_ready;
         tick();
         if (acc) begin
            i_valid = 1'b0;
            return;
         end
      end
      chk("send_timeout", 64'd0, 64'd1);
      i_valid = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_valid"}, 64'(o_valid), 64'd0);
      chk({tag, "_ready"}, 64'(o_ready), 64'd1);
      chk({tag, "_op"},    64'(o_operation), 64'h3F);
      chk({tag, "_data"},  {o_datoA, o_datoB}, 64'd0);
      chk({tag, "_ctl"},   64'({o_shamt, o_wr_reg, o_wr_en, o_illegal}), 64'd0);
   endtask

   task automatic stats_check(input string tag);
`ifdef ALU_ISSUE_STATS_EN
      chk({tag, "_issue_cnt"}, 64'(o_issue_count), 64'(exp_issue));
      chk({tag, "_illegal_cnt"}, 64'(o_illegal_count), 64'(exp_illc & 32'hFFFF));
`endif
   endtask

   initial begin
      rst_n = 1'b0; i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b0;
      i_instruction = '0; i_rs_data = '0; i_rt_data = '0;
      tick(); tick();
      chk_reset_outputs("reset");
      @(negedge clk); rst_n = 1'b1;
      tick();

      // add $3,$1,$2 with one-cycle latency
      i_ready = 1'b1;
      send(32'h00221820, 32'd5, 32'd7);
      chk("add_valid", 64'(o_valid), 64'd1);
      chk("add_fields", {o_datoA, o_datoB}, {32'd5, 32'd7});
      chk("add_ctl", 64'({o_operation, o_wr_reg, o_wr_en}), 64'({6'h20, 5'd3, 1'b1}));

      // Immediate extension
      send(32'h2022FFFF, 32'd1, 32'd2);
      chk("addi_b", 64'({o_operation, o_datoB, o_wr_reg}), 64'({6'h08, 32'hFFFFFFFF, 5'd2}));
      send(32'h3022FFFF, 32'd1, 32'd2);
      chk("andi_b", 64'(o_datoB), 64'h0000FFFF);
      send(32'h3C01ABCD, 32'd0, 32'd0);
      chk("lui", 64'({o_operation, o_datoB, o_shamt}), 64'({6'h0F, 32'h0000ABCD, 5'd0}));

      // Illegal and NOP
      send(32'h8C220000, 32'd9, 32'd9);
      chk("lw_illegal", 64'({o_illegal, o_operation, o_wr_en}), 64'({1'b1, 6'h3F, 1'b0}));
      send(32'h00000000, 32'd3, 32'd4);
      chk("nop", 64'({o_illegal, o_operation, o_wr_en}), 64'({1'b0, 6'h00, 1'b0}));
      tick(); tick();

      // Backpressure: two accepted, third held upstream
      i_ready = 1'b0;
      i_valid = 1'b1; i_instruction = 32'h00221822; i_rs_data = 32'd10; i_rt_data = 32'd3;
      tick();
      i_instruction = 32'h00221824; i_rs_data = 32'd11;
      tick();
      chk("bp_ready_low", 64'(o_ready), 64'd0);
      chk("bp_head", 64'(o_operation), 64'h22);
      i_instruction = 32'h00221825; i_rs_data = 32'd12;
      tick(); tick();
      chk("bp_still_full", 64'({o_ready, o_valid}), 64'b01);
      i_ready = 1'b1;
      send(32'h00221825, 32'd12, 32'd3);
      tick(); tick(); tick();
      chk("bp_drained", 64'(sb_q.size()), 64'd0);
      stats_check("bp");

      // Flush while FULL with a new input offered
      i_ready = 1'b0;
      i_valid = 1'b1; i_instruction = 32'h20420001;
      tick(); tick();
      i_flush = 1'b1; i_instruction = 32'h00431020;
      tick();
      i_flush = 1'b0; i_valid = 1'b0;
      chk_reset_outputs("flush");
      stats_check("flush");
      i_ready = 1'b1;
      tick(); tick(); tick();

      // Asynchronous reset in the middle of a FULL cycle
      i_ready = 1'b0;
      i_valid = 1'b1; i_instruction = 32'h34A5_1234;
      tick(); tick();
      i_valid = 1'b0;
      @(negedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("async_rst");
      sb_q.delete(); exp_issue = 0; exp_illc = 0;
      @(negedge clk); rst_n = 1'b1;
      tick();
      i_ready = 1'b1;
      send(32'h00221820, 32'd1, 32'd1);
      chk("post_rst_latency", 64'(o_valid), 64'd1);

      // Randomized traffic with occasional flushes
      for (int c = 0; c < 3000; c++) begin
         i_valid       = ($urandom_range(0, 3) != 0);
         i_instruction = rand_instr();
         i_rs_data     = $urandom;
         i_rt_data     = $urandom;
         i_ready       = ($urandom_range(0, 2) != 0);
         i_flush       = ($urandom_range(0, 63) == 0);
         tick();
      end
      i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
      for (int c = 0; c < 20 && sb_q.size() != 0; c++) tick();
      tick();
      chk("rand_drained", 64'(sb_q.size()), 64'd0);
      chk("rand_idle", 64'({o_valid, o_ready}), 64'b01);
      stats_check("rand");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
